// File: rtl/rstring_trip_sequencer.sv
// rstring_trip_sequencer
//   Digital control end of the POR trip-voltage select. A 3-bit trip code is
//   decoded to a one-hot tap select for the resistor-string mux. On every
//   code change the bus is driven all-zero for BBM_CYCLES before the new tap
//   is selected (break-before-make). A settle timer then raises `settled`.
//
// Ports
//   clk            block clock, rising edge
//   rst            synchronous active-high reset
//   ena            block enable from POR top
//   otrip[2:0]     requested trip code (0 = vtrip_0 highest tap)
//   load           single-cycle request to apply otrip
//   otrip_decoded  one-hot tap select (bit k selects vtrip_k), or all-zero
//   mux_ena        resistor-string mux enable
//   busy           BBM or SETTLE sequence in progress
//   settled        current tap has been driven for SETTLE_CYCLES
//   cur_code[2:0]  code currently driven, valid while settled
module rstring_trip_sequencer #(
  parameter int unsigned BBM_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] otrip,
  input  logic       load,
  output logic [7:0] otrip_decoded,
  output logic       mux_ena,
  output logic       busy,
  output logic       settled,
  output logic [2:0] cur_code
);

  typedef enum logic [1:0] {
    S_OFF,
    S_BBM,
    S_SETTLE,
    S_STABLE
  } state_t;

  localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             pend_q, pend_d;
  logic [2:0]       pcode_q, pcode_d;
  logic [2:0]       tgt_q, tgt_d;
  logic [7:0]       dec_q, dec_d;
  logic             mux_q, mux_d;
  logic             busy_q, busy_d;
  logic             set_q, set_d;
  logic [2:0]       cur_q, cur_d;
  logic             eff_pend;
  logic [2:0]       eff_code;

  function automatic logic [7:0] onehot(input logic [2:0] c);
    return 8'd1 << c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pcode_d = pcode_q;
    tgt_d   = tgt_q;
    dec_d   = dec_q;
    mux_d   = mux_q;
    busy_d  = busy_q;
    set_d   = set_q;
    cur_d   = cur_q;

    // Saturating decrement: the counter never wraps below zero.
    cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    // A load arriving on the final SETTLE cycle counts as pending too.
    eff_pend = load | pend_q;
    eff_code = load ? otrip : pcode_q;

    if (state_q == S_OFF) begin
      if (ena) begin
        // Bus is already zero, so no BBM phase on entry.
        state_d = S_SETTLE;
        mux_d   = 1'b1;
        dec_d   = onehot(otrip);
        cur_d   = otrip;
        busy_d  = 1'b1;
        set_d   = 1'b0;
        cnt_d   = SETTLE_LOAD;
        pend_d  = 1'b0;
      end
    end else if (!ena) begin
      // Abort whatever is in flight; cur_code keeps the last driven code.
      state_d = S_OFF;
      dec_d   = '0;
      mux_d   = 1'b0;
      busy_d  = 1'b0;
      set_d   = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_BBM: begin
          if (load) begin
            pend_d  = 1'b1;
            pcode_d = otrip;
          end
          if (cnt_q == '0) begin
            state_d = S_SETTLE;
            dec_d   = onehot(tgt_q);
            cur_d   = tgt_q;
            cnt_d   = SETTLE_LOAD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_dec;
            if (load) begin
              pend_d  = 1'b1;
              pcode_d = otrip;
            end
          end else begin
            pend_d = 1'b0;
            if (eff_pend && (eff_code != cur_q)) begin
              // Chain straight into the next break; settled never pulses.
              state_d = S_BBM;
              tgt_d   = eff_code;
              dec_d   = '0;
              cnt_d   = BBM_LOAD;
            end else begin
              state_d = S_STABLE;
              set_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
        S_STABLE: begin
          if (load && (otrip != cur_q)) begin
            state_d = S_BBM;
            tgt_d   = otrip;
            dec_d   = '0;
            set_d   = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = BBM_LOAD;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pcode_q <= '0;
      tgt_q   <= '0;
      dec_q   <= '0;
      mux_q   <= 1'b0;
      busy_q  <= 1'b0;
      set_q   <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pcode_q <= pcode_d;
      tgt_q   <= tgt_d;
      dec_q   <= dec_d;
      mux_q   <= mux_d;
      busy_q  <= busy_d;
      set_q   <= set_d;
      cur_q   <= cur_d;
    end
  end

  assign otrip_decoded = dec_q;
  assign mux_ena       = mux_q;
  assign busy          = busy_q;
  assign settled       = set_q;
  assign cur_code      = cur_q;

endmodule

// File: tb/tb_rstring_trip_sequencer.sv
// tb_rstring_trip_sequencer
//   Directed test-plan steps followed by random stimulus, all checked every
//   cycle against a timestamp-based reference model: each tap is described by
//   the cycle it appears on the bus, and every output is derived from that.
module tb_rstring_trip_sequencer;

  localparam int BBM = 4;
  localparam int SET = 16;

  logic       clk = 1'b0;
  logic       rst, ena, load;
  logic [2:0] otrip;
  logic [7:0] otrip_decoded;
  logic       mux_ena, busy, settled;
  logic [2:0] cur_code;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  rstring_trip_sequencer #(
    .BBM_CYCLES(BBM),
    .SETTLE_CYCLES(SET),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .otrip(otrip),
    .load(load),
    .otrip_decoded(otrip_decoded),
    .mux_ena(mux_ena),
    .busy(busy),
    .settled(settled),
    .cur_code(cur_code)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_on   = 1'b0;
  int m_code = 0;   // code of the tap being (or about to be) driven
  int m_prev = 0;   // code shown on cur_code until m_tap is reached
  int m_tap  = 0;   // cycle at which m_code appears on the bus
  bit m_pend = 1'b0;
  int m_pcode = 0;
  int edge_n = 0;

  function automatic void start_switch(int e, int code);
    m_prev = m_code;
    m_code = code;
    m_tap  = e + 1 + BBM;
  endfunction

  // Apply the inputs sampled at edge e; outputs then describe cycle e+1.
  function automatic void model_edge(int e);
    int  done_e, vis, pc;
    bit  pv;
    if (rst) begin
      m_on = 0; m_code = 0; m_prev = 0; m_tap = 0; m_pend = 0;
    end else if (!m_on) begin
      if (ena) begin
        m_on = 1; m_code = int'(otrip); m_prev = int'(otrip);
        m_tap = e + 1; m_pend = 0;
      end
    end else if (!ena) begin
      vis = (e >= m_tap) ? m_code : m_prev;
      m_code = vis; m_prev = vis; m_on = 0; m_pend = 0;
    end else begin
      done_e = m_tap + SET - 1;
      if (e < done_e) begin
        if (load) begin m_pend = 1; m_pcode = int'(otrip); end
      end else if (e == done_e) begin
        pv = load || m_pend;
        pc = load ? int'(otrip) : m_pcode;
        m_pend = 0;
        if (pv && pc != m_code) start_switch(e, pc);
      end else if (load && int'(otrip) != m_code) begin
        start_switch(e, int'(otrip));
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_model(int t);
    logic [7:0] e_dec;
    logic       e_set;
    e_dec = (m_on && t >= m_tap) ? (8'd1 << m_code) : 8'h00;
    e_set = m_on && (t >= m_tap + SET);
    chk("otrip_decoded", otrip_decoded, e_dec);
    chk("mux_ena", {7'd0, mux_ena}, {7'd0, m_on});
    chk("settled", {7'd0, settled}, {7'd0, e_set});
    chk("busy", {7'd0, busy}, {7'd0, m_on && !e_set});
    chk("cur_code", {5'd0, cur_code}, 8'((t >= m_tap) ? m_code : m_prev));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(edge_n);
    edge_n++;
    #1;
    check_model(edge_n);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_load(input logic [2:0] code);
    otrip = code; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Bus invariant: zero or one-hot, never non-zero to a different non-zero.
  bit         armed = 1'b0;
  logic [7:0] last_dec = 8'h00;
  always @(negedge clk) begin
    if (armed) begin
      n_assert++;
      assert ($onehot0(otrip_decoded)) else begin
        n_fail++;
        $error("FAIL onehot0: observed=%h expected=zero-or-onehot", otrip_decoded);
      end
      n_assert++;
      assert (!(last_dec != 8'h00 && otrip_decoded != 8'h00 && last_dec != otrip_decoded)) else begin
        n_fail++;
        $error("FAIL bbm_break: observed=%h after %h expected=00 in between", otrip_decoded, last_dec);
      end
      last_dec = otrip_decoded;
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; load = 1'b0; otrip = 3'd0;
    ticks(2);
    armed = 1'b1;
    chk("reset_dec", otrip_decoded, 8'h00);
    chk("reset_flags", {4'd0, mux_ena, busy, settled, 1'b0}, 8'h00);
    chk("reset_cur", {5'd0, cur_code}, 8'h00);

    // Enable from OFF with code 3: no BBM, settled 16 cycles later.
    rst = 1'b0; ena = 1'b1; otrip = 3'd3;
    tick();
    chk("first_tap", otrip_decoded, 8'h08);
    chk("first_busy", {6'd0, mux_ena, busy}, 8'h03);
    ticks(15);
    chk("first_not_settled", {7'd0, settled}, 8'h00);
    tick();
    chk("first_settled", {6'd0, settled, busy}, 8'h02);
    chk("first_cur", {5'd0, cur_code}, 8'h03);

    // Switch 3 -> 6 from STABLE.
    pulse_load(3'd6);
    chk("bbm_zero_start", otrip_decoded, 8'h00);
    ticks(3);
    chk("bbm_zero_end", otrip_decoded, 8'h00);
    tick();
    chk("new_tap_6", otrip_decoded, 8'h40);
    ticks(16);
    chk("settled_6", {7'd0, settled}, 8'h01);

    // Same-code load is ignored.
    pulse_load(3'd6);
    chk("same_code_busy", {7'd0, busy}, 8'h00);
    chk("same_code_dec", otrip_decoded, 8'h40);

    // Go to 4, then back toward 6 and queue 1 then 2 during SETTLE.
    pulse_load(3'd4);
    ticks(BBM + SET);
    pulse_load(3'd6);
    ticks(6);
    pulse_load(3'd1);
    tick();
    pulse_load(3'd2);
    ticks(40);
    chk("pending_last_wins", otrip_decoded, 8'h04);

    // Drop ena in the middle of BBM, then re-enable with code 0.
    pulse_load(3'd5);
    tick();
    ena = 1'b0;
    tick();
    chk("abort_dec", otrip_decoded, 8'h00);
    chk("abort_flags", {5'd0, mux_ena, busy, settled}, 8'h00);
    tick();
    ena = 1'b1; otrip = 3'd0;
    tick();
    chk("reenable_tap0", otrip_decoded, 8'h01);
    ticks(16);
    chk("reenable_settled", {7'd0, settled}, 8'h01);

    // Reset mid-SETTLE with ena held high.
    pulse_load(3'd7);
    ticks(BBM + 3);
    rst = 1'b1;
    tick();
    chk("rst_mid_dec", otrip_decoded, 8'h00);
    chk("rst_mid_flags", {5'd0, mux_ena, busy, settled}, 8'h00);
    rst = 1'b0; otrip = 3'd2;
    tick();
    chk("rst_restart", otrip_decoded, 8'h04);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 79) == 0) ena = ~ena;
      load  = ($urandom_range(0, 4) == 0);
      otrip = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; load = 1'b0;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
